// File: rtl/sub_if.sv
// Operand/result handshake bundle for sub_pipe.
// The overflow signal exists only when SUB_OVERFLOW_EN is defined.
interface sub_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
`ifdef SUB_OVERFLOW_EN
  logic        overflow;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
`ifdef SUB_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
`ifdef SUB_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/sub_pipe.sv
// Two-stage 32-bit subtractor (low half, then high half) with valid/ready flow control.
// Optional signed overflow flag enabled by defining SUB_OVERFLOW_EN.
module sub_pipe (
  input logic clk,
  input logic rst,
  sub_if.slave bus
);

  // 16-bit adder from four 4-bit lookahead groups; returns {carry_out, sum}.
  function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    return {gc[4], p ^ c};
  endfunction

  logic        s1_valid_q;
  logic [15:0] s1_dlo_q;
  logic        s1_c16_q;
  logic [15:0] s1_ahi_q;
  logic [15:0] s1_bhi_q;
  logic        s2_valid_q;
  logic [31:0] diff_q;
  logic        borrow_q;

  logic        s1_adv;
  logic        in_ready;
  logic        accept;
  logic [16:0] lo_sum;
  logic [16:0] hi_sum;

  always_comb begin
    s1_adv   = !s2_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s1_adv;
    accept   = bus.in_valid && in_ready;
    lo_sum   = cla16(bus.a[15:0], ~bus.b[15:0], 1'b1);
    hi_sum   = cla16(s1_ahi_q, ~s1_bhi_q, s1_c16_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= '0;
      s1_c16_q   <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= bus.in_valid;
      if (accept) begin
        s1_dlo_q <= lo_sum[15:0];
        s1_c16_q <= lo_sum[16];
        s1_ahi_q <= bus.a[31:16];
        s1_bhi_q <= bus.b[31:16];
      end
    end
  end

  // Result registers only load on a real result so they hold while empty or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        diff_q   <= {hi_sum[15:0], s1_dlo_q};
        borrow_q <= ~hi_sum[16];
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic s1_sa_q;
  logic s1_sb_q;
  logic overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sa_q <= 1'b0;
      s1_sb_q <= 1'b0;
    end else if (accept) begin
      s1_sa_q <= bus.a[31];
      s1_sb_q <= bus.b[31];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (s1_adv && s1_valid_q) begin
      overflow_q <= (s1_sa_q != s1_sb_q) && (hi_sum[15] != s1_sa_q);
    end
  end

  assign bus.overflow = overflow_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule
